// File: rtl/shift_out.sv
// shift_out: parallel-to-serial transmitter; sends a WIDTH-bit word one bit per clock
// with a valid strobe, then raises a sticky done flag.
module shift_out #(
    parameter int WIDTH     = 24,
    parameter int CNT_W     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sp,
    input  logic [WIDTH-1:0] p_parallel,
    output logic             p_out,
    output logic             p_valid,
    output logic             busy,
    output logic             fp
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFTING = 2'd1, DONE = 2'd2} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   count_q;
    logic               sp_q;
    logic               start;
    // sp_q resets high so a request held through reset cannot start a word
    assign start = sp & ~sp_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            sp_q    <= 1'b1;
            p_out   <= 1'b0;
            p_valid <= 1'b0;
            busy    <= 1'b0;
            fp      <= 1'b0;
        end else begin
            sp_q <= sp;
            case (state_q)
                IDLE, DONE: if (start) begin
                    shreg_q <= p_parallel;
                    count_q <= '0;
                    state_q <= SHIFTING;
                    fp      <= 1'b0;
                    p_valid <= 1'b1;
                    busy    <= 1'b1;
                    p_out   <= MSB_FIRST ? p_parallel[WIDTH-1] : p_parallel[0];
                end
                SHIFTING: if (count_q == LAST) begin
                    state_q <= DONE;
                    p_out   <= 1'b0;
                    p_valid <= 1'b0;
                    busy    <= 1'b0;
                    fp      <= 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                    shreg_q <= MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
                    p_out   <= MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
                end
                default: begin
                    state_q <= IDLE;
                    p_out   <= 1'b0;
                    p_valid <= 1'b0;
                    busy    <= 1'b0;
                    fp      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_out.sv
// tb_shift_out: drives three transmitter variants (24b MSB-first, 24b LSB-first, 12b MSB-first)
// from one start line and checks them against a bit-list reference model.
module tb_shift_out;
    logic        clk, reset, sp;
    logic [23:0] p_par;
    logic [11:0] p12;
    logic [2:0]  so, sv, sb, sf;
    int          total = 0, bad = 0;
    shift_out #(.WIDTH(24), .CNT_W(6), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .sp(sp),
        .p_parallel(p_par), .p_out(so[0]), .p_valid(sv[0]), .busy(sb[0]), .fp(sf[0]));
    shift_out #(.WIDTH(24), .CNT_W(6), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .sp(sp),
        .p_parallel(p_par), .p_out(so[1]), .p_valid(sv[1]), .busy(sb[1]), .fp(sf[1]));
    shift_out #(.WIDTH(12), .CNT_W(4), .MSB_FIRST(1'b1)) u_12 (.clk(clk), .reset(reset), .sp(sp),
        .p_parallel(p12), .p_out(so[2]), .p_valid(sv[2]), .busy(sb[2]), .fp(sf[2]));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // Reference: a word is a list of bits in send order; one list entry is shown per cycle.
    // expv packs {p_out, p_valid, busy, fp}.
    logic [3:0]  expv [3];
    logic [23:0] wd [3];
    int          pos [3];
    logic        prev_sp;
    function automatic int wid(input int i);
        return (i == 2) ? 12 : 24;
    endfunction
    function automatic logic bit_at(input logic [23:0] w, input int i, input int k);
        return (i == 1) ? w[k] : w[wid(i) - 1 - k];
    endfunction
    function automatic logic [23:0] word_of(input int i);
        return (i == 2) ? {12'h000, p12} : p_par;
    endfunction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sp <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                expv[i] <= 4'b0000;
                pos[i]  <= 0;
                wd[i]   <= '0;
            end
        end else begin
            prev_sp <= sp;
            for (int i = 0; i < 3; i++) begin
                if (expv[i][2]) begin
                    if (pos[i] < wid(i)) begin
                        expv[i] <= {bit_at(wd[i], i, pos[i]), 3'b110};
                        pos[i]  <= pos[i] + 1;
                    end else expv[i] <= 4'b0001;
                end else if (sp && !prev_sp) begin
                    wd[i]   <= word_of(i);
                    expv[i] <= {bit_at(word_of(i), i, 0), 3'b110};
                    pos[i]  <= 1;
                end
            end
        end
    end
    task automatic test_reset;
        reset = 1'b1; sp = 1'b1; p_par = '0; p12 = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({so, sv, sb, sf} !== 12'h000) begin
            bad++; $display("FAIL reset_values got=%h exp=000", {so, sv, sb, sf});
        end
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            total++;
            if (sv !== 3'b000) begin
                bad++; $display("FAIL held_sp_no_start cyc%0d got=%b exp=000", c, sv);
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({so[i], sv[i], sb[i], sf[i]} !== expv[i]) begin
                    bad++; $display("FAIL held_sp inst%0d cyc%0d got=%b exp=%b", i, c, {so[i], sv[i], sb[i], sf[i]}, expv[i]);
                end
            end
        end
        sp = 1'b0; p_par = 24'h5A5A5A; p12 = 12'hABC;
        @(negedge clk);
        sp = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++;
                if ({sv, sb} !== 6'b111111) begin
                    bad++; $display("FAIL first_start got=%b exp=111111", {sv, sb});
                end
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({so[i], sv[i], sb[i], sf[i]} !== expv[i]) begin
                    bad++; $display("FAIL first_word inst%0d cyc%0d got=%b exp=%b", i, c, {so[i], sv[i], sb[i], sf[i]}, expv[i]);
                end
            end
        end
    endtask
    task automatic test_stream(input logic [23:0] w, input logic [11:0] w12, input bit toggle,
                               input logic [23:0] exp_msb, input logic [23:0] exp_lsb);
        logic [23:0] r0, r1;
        logic [11:0] r2;
        int n;
        r0 = '0; r1 = '0; r2 = '0; n = 0;
        sp = 1'b0; p_par = w; p12 = w12;
        @(negedge clk);
        sp = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({so[i], sv[i], sb[i], sf[i]} !== expv[i]) begin
                    bad++; $display("FAIL stream inst%0d cyc%0d got=%b exp=%b", i, c, {so[i], sv[i], sb[i], sf[i]}, expv[i]);
                end
            end
            if (sv[0]) begin r0 = {r0[22:0], so[0]}; n++; end
            if (sv[1]) r1 = {r1[22:0], so[1]};
            if (sv[2]) r2 = {r2[10:0], so[2]};
            if (c == 0) begin p_par = ~w; p12 = ~w12; end
            if (toggle && c == 10) sp = 1'b0;
            if (toggle && c == 11) sp = 1'b1;
        end
        total += 5;
        if (r0 !== exp_msb) begin bad++; $display("FAIL stream_msb got=%h exp=%h", r0, exp_msb); end
        if (r1 !== exp_lsb) begin bad++; $display("FAIL stream_lsb got=%h exp=%h", r1, exp_lsb); end
        if (r2 !== w12) begin bad++; $display("FAIL stream_12 got=%h exp=%h", r2, w12); end
        if (n != 24) begin bad++; $display("FAIL valid_len got=%0d exp=24", n); end
        if (sf !== 3'b111) begin bad++; $display("FAIL done_sticky got=%b exp=111", sf); end
    endtask
    task automatic test_reset_mid;
        sp = 1'b0; p_par = 24'hA5C3F0; p12 = 12'h9B6;
        @(negedge clk);
        sp = 1'b1;
        for (int c = 0; c < 8; c++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({so, sv, sb, sf} !== 12'h000) begin
            bad++; $display("FAIL async_reset got=%h exp=000", {so, sv, sb, sf});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({sv, sf} !== 6'b000000) begin
                bad++; $display("FAIL post_reset_idle cyc%0d got=%b exp=000000", c, {sv, sf});
            end
        end
        test_stream(24'hA5C3F0, 12'h9B6, 1'b0, 24'hA5C3F0, 24'h0FC3A5);
    endtask
    task automatic test_loopback;
        logic [23:0] w;
        logic [11:0] w12, rx;
        for (int n = 0; n < 200; n++) begin
            w = 24'($urandom); w12 = 12'($urandom); rx = '0;
            sp = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            p_par = w; p12 = w12; sp = 1'b1;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if ({so[i], sv[i], sb[i], sf[i]} !== expv[i]) begin
                        bad++; $display("FAIL loop w%0d inst%0d cyc%0d got=%b exp=%b", n, i, c, {so[i], sv[i], sb[i], sf[i]}, expv[i]);
                    end
                end
                if (sv[2]) rx = {rx[10:0], so[2]};
                if (c == 12) begin
                    total++;
                    if (sf[2] !== 1'b1) begin bad++; $display("FAIL rx_done w%0d got=%b exp=1", n, sf[2]); end
                end
            end
            total++;
            if (rx !== w12) begin bad++; $display("FAIL rx_word w%0d got=%h exp=%h", n, rx, w12); end
        end
    endtask
    initial begin
        test_reset;
        test_stream(24'hA5C3F0, 12'h9B6, 1'b0, 24'hA5C3F0, 24'h0FC3A5);
        test_stream(24'hA5C3F0, 12'h9B6, 1'b1, 24'hA5C3F0, 24'h0FC3A5);
        test_stream(24'h000001, 12'h001, 1'b0, 24'h000001, 24'h800000);
        test_reset_mid;
        test_loopback;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
